// File: rtl/imm_narrower.sv
// Narrows a 32-bit signed word to a 16-bit immediate behind a one-deep valid/ready stage.
// Optional macro IMM_NARROWER_SAT_EN clamps non-fitting words instead of truncating them.
module imm_narrower #(
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [31:0]  value_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic        [15:0]  imm_out,
  output logic                fits,
  input  logic                clr_count,
  output logic [CNT_W-1:0]    ovf_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             vld_q, vld_d;
  logic [15:0]      imm_q, imm_d;
  logic             fits_q, fits_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             xfer_in;
  logic             fits_w;

  // Exactly representable in 16 bits when the top 17 bits are all copies of the sign.
  function automatic logic word_fits(input logic signed [31:0] v);
    return (v[31:15] == {17{v[31]}});
  endfunction

  function automatic logic [15:0] narrow(input logic signed [31:0] v, input logic ok);
    logic [15:0] r;
    r = v[15:0];
`ifdef IMM_NARROWER_SAT_EN
    if (!ok) r = v[31] ? 16'h8000 : 16'h7FFF;
`else
    if (!ok) r = v[15:0];
`endif
    return r;
  endfunction

  assign in_ready = !vld_q || out_ready;
  assign xfer_in  = in_valid && in_ready;
  assign fits_w   = word_fits(value_in);

  always_comb begin
    vld_d  = vld_q;
    imm_d  = imm_q;
    fits_d = fits_q;
    cnt_d  = cnt_q;
    if (xfer_in) begin
      vld_d  = 1'b1;
      imm_d  = narrow(value_in, fits_w);
      fits_d = fits_w;
    end else if (out_ready) begin
      vld_d  = 1'b0;
    end
    if (clr_count)
      cnt_d = '0;
    else if (xfer_in && !fits_w && cnt_q != CNT_MAX)
      cnt_d = cnt_q + 1'b1;
  end

  // Output stage: everything visible to the consumer comes straight from these registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q  <= 1'b0;
      imm_q  <= 16'h0000;
      fits_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      imm_q  <= imm_d;
      fits_q <= fits_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out_valid = vld_q;
  assign imm_out   = imm_q;
  assign fits      = fits_q;
  assign ovf_count = cnt_q;

endmodule

// File: tb/tb_imm_narrower.sv
// Randomized and directed bench for imm_narrower; a CNT_W=2 copy shares the stimulus
// so counter saturation is observable in a short run.
module tb_imm_narrower;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, out_ready, clr_count;
  logic [31:0] value_in;
  logic        in_ready, out_valid, fits;
  logic [15:0] imm_out;
  logic [15:0] ovf_count;
  logic        in_ready2, out_valid2, fits2;
  logic [15:0] imm_out2;
  logic [1:0]  ovf_count2;

  int errs = 0;
  int checks = 0;

  // Reference state
  logic        m_vld;
  logic [15:0] m_imm;
  logic        m_fits;
  int          m_cnt16, m_cnt2;

  always #5 clk = ~clk;

  imm_narrower #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .value_in(value_in), .out_valid(out_valid), .out_ready(out_ready),
    .imm_out(imm_out), .fits(fits), .clr_count(clr_count), .ovf_count(ovf_count)
  );

  imm_narrower #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
    .value_in(value_in), .out_valid(out_valid2), .out_ready(out_ready),
    .imm_out(imm_out2), .fits(fits2), .clr_count(clr_count), .ovf_count(ovf_count2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic ref_fits(input logic [31:0] v);
    longint s;
    s = longint'($signed(v));
    return (s >= -32768) && (s <= 32767);
  endfunction

  function automatic logic [15:0] ref_imm(input logic [31:0] v);
    longint s;
    s = longint'($signed(v));
    if (ref_fits(v)) return v[15:0];
`ifdef IMM_NARROWER_SAT_EN
    return (s > 0) ? 16'h7FFF : 16'h8000;
`else
    return v[15:0];
`endif
  endfunction

  task automatic model_reset();
    m_vld = 1'b0; m_imm = 16'h0000; m_fits = 1'b0; m_cnt16 = 0; m_cnt2 = 0;
  endtask

  task automatic check_outputs();
    check("out_valid", 32'(out_valid), 32'(m_vld));
    check("imm_out", 32'(imm_out), 32'(m_imm));
    check("fits", 32'(fits), 32'(m_fits));
    check("ovf_count", 32'(ovf_count), 32'(m_cnt16));
    check("ovf_count_w2", 32'(ovf_count2), 32'(m_cnt2));
    check("imm_out_w2", 32'(imm_out2), 32'(m_imm));
  endtask

  // Called just after a rising edge: drive, check in_ready, clock once, check outputs.
  task automatic step(input logic iv, input logic [31:0] v, input logic ordy, input logic clr);
    logic rdy, xin;
    in_valid = iv; value_in = v; out_ready = ordy; clr_count = clr;
    #1;
    rdy = !m_vld || ordy;
    check("in_ready", 32'(in_ready), 32'(rdy));
    check("in_ready_w2", 32'(in_ready2), 32'(rdy));
    xin = iv && rdy;
    @(posedge clk); #1;
    if (xin) begin
      m_vld = 1'b1; m_imm = ref_imm(v); m_fits = ref_fits(v);
    end else if (ordy) begin
      m_vld = 1'b0;
    end
    if (clr) begin
      m_cnt16 = 0; m_cnt2 = 0;
    end else if (xin && !ref_fits(v)) begin
      if (m_cnt16 < 65535) m_cnt16++;
      if (m_cnt2 < 3) m_cnt2++;
    end
    check_outputs();
  endtask

  initial begin
    logic [31:0] v;
    reset = 1'b1; in_valid = 0; out_ready = 0; clr_count = 0; value_in = '0;
    model_reset();
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check_outputs();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    // Most negative fitting value
    step(1, 32'hFFFF_8000, 1, 0);
    check("min_fit_imm", 32'(imm_out), 32'h8000);
    check("min_fit_fits", 32'(fits), 32'd1);

    // Non-fitting positive word
    step(1, 32'h0001_2345, 1, 0);
    check("ovf_fits", 32'(fits), 32'd0);
    check("ovf_cnt1", 32'(ovf_count), 32'd1);
`ifdef IMM_NARROWER_SAT_EN
    check("ovf_imm", 32'(imm_out), 32'h7FFF);
`else
    check("ovf_imm", 32'(imm_out), 32'h2345);
`endif

    // Backpressure hold, then back-to-back replace
    step(1, 32'h0000_7FFF, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 32'h0000_1111, 0, 0);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_imm", 32'(imm_out), 32'h7FFF);
    end
    step(1, 32'h0000_0001, 1, 0);
    check("b2b_imm", 32'(imm_out), 32'h0001);
    check("b2b_valid", 32'(out_valid), 32'd1);
    step(0, 32'h0, 1, 0);
    check("drain_valid", 32'(out_valid), 32'd0);

    // Saturation of the 2-bit counter
    step(0, 32'h0, 1, 1);
    for (int i = 0; i < 4; i++) begin
      step(1, 32'h8000_0000, 1, 0);
      check("sat_seq_w2", 32'(ovf_count2), (i < 3) ? i + 1 : 3);
    end

    // Clear wins over increment
    step(0, 32'h0, 1, 1);
    step(1, 32'h8000_0000, 1, 0);
    step(1, 32'h8000_0000, 1, 0);
    check("pre_clr_cnt", 32'(ovf_count), 32'd2);
    step(1, 32'h8000_0000, 1, 1);
    check("clr_wins", 32'(ovf_count), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 2))
        0: v = {{16{$urandom_range(0, 1) == 1}}, 16'($urandom)};
        1: v = 32'(signed'($urandom_range(0, 7)) - 4) + (($urandom_range(0, 1) == 1) ? 32'h0000_8000 : 32'hFFFF_8000);
        default: v = $urandom;
      endcase
      step($urandom_range(0, 3) != 0, v, $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
    end

    // Asynchronous reset with a stalled result
    step(1, 32'h0000_7000, 1, 0);
    step(1, 32'h9000_0000, 0, 0);
    in_valid = 0; out_ready = 0;
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_ovf", 32'(ovf_count), 32'd0);
    check_outputs();
    @(posedge clk); #1;
    reset = 1'b0;
    step(0, 32'h0, 0, 0);
    check("no_stale", 32'(out_valid), 32'd0);
    step(0, 32'h0, 1, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/imm_narrower.md
IMM_NARROWER -- requirements
Module: imm_narrower

Interface
REQ-001 SHALL have parameter CNT_W, default 16, giving the width of the overflow event counter.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1 bit: value_in holds a word to narrow.
REQ-005 SHALL have port in_ready, output, 1 bit: the block accepts a word this cycle.
REQ-006 SHALL have port value_in, input, 32 bits: the 32-bit signed word to narrow.
REQ-007 SHALL have port out_valid, output, 1 bit: imm_out and fits hold a result.
REQ-008 SHALL have port out_ready, input, 1 bit: the consumer accepts the result this cycle.
REQ-009 SHALL have port imm_out, output, 16 bits: the narrowed 16-bit immediate.
REQ-010 SHALL have port fits, output, 1 bit: the accepted word was exactly representable as a 16-bit signed value.
REQ-011 SHALL have port clr_count, input, 1 bit: synchronous clear of ovf_count.
REQ-012 SHALL have port ovf_count, output, CNT_W bits: number of accepted words that did not fit.

Function
REQ-013 SHALL perform the inverse of 16-to-32 sign extension: fits=1 exactly when value_in[31:15] are all equal.
REQ-014 SHALL drive imm_out = value_in[15:0] when fits=1, regardless of configuration.
REQ-015 SHALL define a transfer in as in_valid && in_ready, and a transfer out as out_valid && out_ready.
REQ-016 SHALL drive in_ready = !out_valid || out_ready (single-stage registered pipeline; full throughput).
REQ-017 SHALL register imm_out and fits on a transfer in, with out_valid rising on the next edge (latency 1 cycle).
REQ-018 SHALL clear out_valid after a transfer out with no simultaneous transfer in; a simultaneous transfer in SHALL keep out_valid at 1 and replace the data.
REQ-019 SHALL hold imm_out and fits stable while out_valid=1 and out_ready=0.
REQ-020 SHALL increment ovf_count by 1 on each transfer in with fits=0.
REQ-021 SHALL saturate ovf_count at all ones (no wrap).
REQ-022 SHALL let clr_count win over a simultaneous increment: ovf_count becomes 0 on that edge.
REQ-023 SHALL have imm_out, fits and ovf_count as pure functions of registered state.

Reset
REQ-024 SHALL, on reset assertion and independent of clk, force out_valid=0, imm_out=16'h0000, fits=0 and ovf_count=0.
REQ-025 SHALL give in_ready=1 while reset is asserted and after reset is released.
REQ-026 SHALL discard a result held mid-handshake when reset is asserted; it is not presented after release.

Configuration
REQ-027 SHALL implement saturation under the macro IMM_NARROWER_SAT_EN.
- Macro defined: a non-fitting word gives imm_out=16'h7FFF when value_in[31]=0, or 16'h8000 when value_in[31]=1.
- Macro undefined: a non-fitting word gives imm_out=value_in[15:0] (truncation).
- Both cases: fits=0 and the counter increments.

Verification
REQ-028 SHALL cover: value_in=32'hFFFF_8000 accepted with out_ready=1 -> next cycle out_valid=1, imm_out=16'h8000, fits=1, ovf_count=0.
REQ-029 SHALL cover: value_in=32'h0001_2345 accepted -> fits=0, ovf_count=1, and imm_out is 16'h7FFF when IMM_NARROWER_SAT_EN is defined, or 16'h2345 when it is undefined.
REQ-030 SHALL cover: out_ready=0 for 3 cycles after 32'h0000_7FFF is accepted -> in_ready=0, and imm_out=16'h7FFF/fits=1 stay stable; a following out_ready=1 with in_valid=1 and value 32'h0000_0001 -> back-to-back transfer, next imm_out=16'h0001.
REQ-031 SHALL cover: with CNT_W=2, four non-fitting words (e.g. 32'h8000_0000) -> ovf_count sequence 1,2,3,3.
REQ-032 SHALL cover: clr_count=1 in the same cycle as a non-fitting transfer with ovf_count=2 -> ovf_count=0 next cycle.
REQ-033 SHALL cover: reset asserted asynchronously mid-cycle while out_valid=1 and out_ready=0 -> out_valid=0, ovf_count=0 and in_ready=1 immediately, and no stale result appears after release.
